// File: rtl/memory_stage.sv
// memory_stage: fourth pipeline stage. Performs byte/halfword/word loads and
// stores over a request/response data-RAM port and presents a registered
// result to writeback. The execute stage is stalled (mem_allowin low) while an
// access is outstanding or while a result waits for writeback.
module memory_stage (
    input  logic        clk,
    input  logic        resetn,            // asynchronous, active-high
    // execute-stage handshake and payload
    input  logic        exe_valid,
    output logic        mem_allowin,
    input  logic [31:0] exe_alu_result,
    input  logic        exe_wen,
    input  logic [4:0]  exe_regsrc,
    input  logic        exe_is_load,
    input  logic        exe_is_store,
    input  logic [1:0]  exe_mem_size,
    input  logic        exe_load_unsigned,
    input  logic [31:0] exe_store_data,
    // data RAM request/response port
    output logic        data_req,
    output logic        data_wr,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    // writeback handshake and payload
    output logic        mem_valid,
    input  logic        wb_allowin,
    output logic [31:0] mem_result,
    output logic        mem_wen,
    output logic [4:0]  mem_regsrc,
    output logic        mem_misalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t state, next_state;

    // Fields captured on accept, needed when the load response returns.
    logic [31:0] cap_addr;
    logic        cap_wen;
    logic [4:0]  cap_regsrc;
    logic        cap_is_load;
    logic [1:0]  cap_size;
    logic        cap_unsigned;

    logic        accept;
    logic        exe_is_mem;
    logic        exe_misalign;
    logic        start_access;
    logic [3:0]  store_wstrb;
    logic [31:0] store_wdata;
    logic [31:0] load_value;
    logic [31:0] byte_shifted;
    logic [15:0] half_sel;

    // State register: the FSM only tracks where the outstanding access is.
    always_ff @(posedge clk or posedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (resetn) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic: addr_ok is only looked at in REQ, data_ok only in WAIT.
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        case (state)
            S_IDLE: if (start_access) next_state = S_REQ;
            S_REQ:  if (data_addr_ok) next_state = S_WAIT;
            S_WAIT: if (data_data_ok) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output/decode logic: handshake, alignment check, store lane steering.
    always_comb begin
        mem_allowin  = (state == S_IDLE) && (!mem_valid || wb_allowin) && !resetn;
        accept       = exe_valid && mem_allowin;
        exe_is_mem   = exe_is_load || exe_is_store;
        exe_misalign = 1'b0;
        store_wstrb  = 4'b1111;
        store_wdata  = exe_store_data;
        case (exe_mem_size)
            2'b00: begin
                store_wstrb = 4'b0001 << exe_alu_result[1:0];
                store_wdata = {4{exe_store_data[7:0]}};
            end
            2'b01: begin
                exe_misalign = exe_alu_result[0];
                store_wstrb  = exe_alu_result[1] ? 4'b1100 : 4'b0011;
                store_wdata  = {2{exe_store_data[15:0]}};
            end
            default: exe_misalign = (exe_alu_result[1:0] != 2'b00);
        endcase
        exe_misalign = exe_misalign && exe_is_mem;
        start_access = accept && exe_is_mem && !exe_misalign;
    end

    // Load lane extraction from the returned word, using captured address/size.
    always_comb begin
        byte_shifted = data_rdata >> {cap_addr[1:0], 3'b000};
        half_sel     = cap_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (cap_size)
            2'b00:   load_value = {{24{byte_shifted[7] & ~cap_unsigned}}, byte_shifted[7:0]};
            2'b01:   load_value = {{16{half_sel[15] & ~cap_unsigned}}, half_sel};
            default: load_value = data_rdata;
        endcase
    end

    // Capture registers for the in-flight instruction.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            cap_addr     <= '0;
            cap_wen      <= 1'b0;
            cap_regsrc   <= '0;
            cap_is_load  <= 1'b0;
            cap_size     <= '0;
            cap_unsigned <= 1'b0;
        end else if (accept) begin
            cap_addr     <= exe_alu_result;
            cap_wen      <= exe_wen;
            cap_regsrc   <= exe_regsrc;
            cap_is_load  <= exe_is_load;
            cap_size     <= exe_mem_size;
            cap_unsigned <= exe_load_unsigned;
        end
    end

    // Data RAM request registers: launched on accept, held until addr_ok.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_addr  <= '0;
            data_wstrb <= '0;
            data_wdata <= '0;
        end else if (start_access) begin
            data_req   <= 1'b1;
            data_wr    <= exe_is_store;
            data_addr  <= {exe_alu_result[31:2], 2'b00};
            data_wstrb <= exe_is_store ? store_wstrb : 4'b0000;
            data_wdata <= store_wdata;
        end else if (state == S_REQ && data_addr_ok) begin
            data_req   <= 1'b0;
        end
    end

    // Writeback-facing result registers and the misalignment pulse.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            mem_valid    <= 1'b0;
            mem_result   <= '0;
            mem_wen      <= 1'b0;
            mem_regsrc   <= '0;
            mem_misalign <= 1'b0;
        end else begin
            mem_misalign <= 1'b0;
            if (accept && !start_access) begin
                // Non-memory or dropped misaligned access completes at once.
                mem_valid    <= 1'b1;
                mem_result   <= exe_alu_result;
                mem_wen      <= exe_wen && !exe_misalign;
                mem_regsrc   <= exe_regsrc;
                mem_misalign <= exe_misalign;
            end else if (state == S_WAIT && data_data_ok) begin
                mem_valid  <= 1'b1;
                mem_result <= cap_is_load ? load_value : cap_addr;
                mem_wen    <= cap_is_load && cap_wen;
                mem_regsrc <= cap_regsrc;
            end else if (wb_allowin) begin
                mem_valid  <= 1'b0;
            end
        end
    end

endmodule
